exu_muldiv: RTL and testbench
=============================

Name: exu_muldiv

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes operand data and an M-extension op code decoded from ALUop, then runs a multi-cycle shift-add / restoring-division datapath.
- Holds the pipeline via stallreq until the result is ready, then presents one registered 64-bit result to the EXU result mux.

Parameters:
- XLEN, 64, operand/result width.
- OP_WIDTH, 4, width of op code.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; aborts any operation
- stall_in  in  1  downstream (EX/MEM) stall; result not yet consumed
- start  in  1  ID/EX holds a valid M-extension instruction
- op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 reserved
- rs1data  in  64  operand A
- rs2data  in  64  operand B
- result  out  64  registered result
- done  out  1  result valid
- stallreq  out  1  request to freeze IF/ID/EX

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low. While rst_n=0 at a posedge: state=IDLE, result=0, done=0, counter=0, internal accumulators=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE with start=1 and flush=0:
  - Latch op and operands (W ops: low 32 bits, sign- or zero-extended per op).
  - Capture signs and convert signed operands to magnitudes.
  - Load counter with 64 (or 32 for W ops).
  - Go to MUL for op 0-3/8, or DIV for op 4-7/9-12.
- Division special cases are resolved in the IDLE sampling cycle and go straight to DONE:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (DIV/REM with MIN and -1; DIVW/REMW with 32-bit MIN and -1): quotient = MIN, remainder = 0.
- MUL state:
  - One shift-add step per cycle into a 128-bit product (64-bit for W).
  - Counter decrements; when it reaches 1, apply sign correction and select the low or high half, then go to DONE.
- DIV state:
  - One restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - At the last step, apply sign fix: quotient negated if operand signs differ; remainder takes the dividend's sign. Then go to DONE.
- DONE state:
  - done=1; result is stable.
  - If stall_in=1, stay in DONE.
  - Otherwise go to IDLE next cycle. start is ignored in DONE, so the same instruction never re-triggers.
- W ops: the 32-bit result is sign-extended to 64 bits (MULW, DIVW, DIVUW, REMW, REMUW all sign-extend).
- Reserved op (13-15) with start: treated as MUL with result 0; not a supported use.
- stallreq is combinational: (IDLE & start & ~flush) | MUL | DIV. It is low in DONE, so ID/EX advances on the cycle done is seen.
- Latency: start sampled at cycle T.
  - 64-bit ops: done=1 at cycle T+65.
  - W ops: done=1 at T+33.
  - Special cases: done=1 at T+1.
- flush (any state): next state IDLE, done=0, result unchanged. flush takes priority over start in the same cycle.
- rst_n=0 mid-operation: immediate return to reset values at that edge, with no partial result.
- result holds its last value after DONE until overwritten by the next completion.

Test Plan:
- MUL: rs1=7, rs2=-3 -> done at T+65, result=0xFFFF_FFFF_FFFF_FFEB; stallreq high for cycles T..T+64.
- MULHU: rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> result=0.
- DIV by zero: rs1=100, rs2=0 -> done at T+1, result=0xFFFF_FFFF_FFFF_FFFF; REM with the same operands -> result=100. DIV with 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000.
- DIVW: rs1=0x1_FFFF_FFF9 (low word -7), rs2=2 -> done at T+33, result=0xFFFF_FFFF_FFFF_FFFD. REMW with the same operands -> result=0xFFFF_FFFF_FFFF_FFFF.
- stall_in held high for 3 cycles at DONE -> done stays 1 for 4 cycles, result constant, no restart while start stays high.
- flush at T+10 of a DIVU -> IDLE at T+11, done never asserted, stallreq low at T+11; rst_n=0 mid-MUL -> result=0 and done=0 the next cycle.

Source files
------------

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV64M multiply/divide unit for the execute stage.
//
// One shift-add step (multiply) or one restoring step (divide) per cycle.
// Operands are converted to magnitudes at start; the sign is re-applied on
// the final step. Divide-by-zero and signed overflow resolve in one cycle.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           abort any operation (wins over start)
//   stall_in        downstream stall; hold DONE while high
//   start, op       valid M-extension instruction and its op code
//   rs1data/rs2data operands A and B
//   result, done    registered result and its valid flag
//   stallreq        combinational request to freeze IF/ID/EX
module exu_muldiv #(
    parameter int XLEN     = 64,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                stall_in,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]     rs1data,
    input  logic [XLEN-1:0]     rs2data,
    output logic [XLEN-1:0]     result,
    output logic                done,
    output logic                stallreq
);

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_MULW   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_DIVUW  = 4'd10;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t state;

    // Latched operation context
    logic [3:0]   op_q;
    logic         w_q;
    logic         rem_q;
    logic         neg_q;      // negate product / quotient
    logic         neg_r;      // negate remainder (dividend sign)
    logic [6:0]   cnt;

    // Multiply datapath
    logic [127:0] acc;
    logic [127:0] mcand;
    logic [63:0]  mplier;

    // Divide datapath
    logic [63:0]  rem;
    logic [63:0]  quo;
    logic [63:0]  divisor;

    // W ops keep only the low word, sign-extended
    function automatic logic [63:0] wfix(input logic w, input logic [63:0] x);
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

    // ---------------------------------------------------------------
    // Op decode
    // ---------------------------------------------------------------
    logic is_w, a_sgn_op, b_sgn_op, is_div_op, is_rem_op;

    always_comb begin
        is_w      = 1'b0;
        a_sgn_op  = 1'b0;
        b_sgn_op  = 1'b0;
        is_div_op = 1'b0;
        is_rem_op = 1'b0;
        case (op)
            OP_MULH:   begin a_sgn_op = 1'b1; b_sgn_op = 1'b1; end
            OP_MULHSU: a_sgn_op = 1'b1;
            OP_DIV:    begin is_div_op = 1'b1; a_sgn_op = 1'b1; b_sgn_op = 1'b1; end
            OP_DIVU:   is_div_op = 1'b1;
            OP_REM:    begin is_div_op = 1'b1; is_rem_op = 1'b1; a_sgn_op = 1'b1; b_sgn_op = 1'b1; end
            OP_REMU:   begin is_div_op = 1'b1; is_rem_op = 1'b1; end
            OP_MULW:   is_w = 1'b1;
            OP_DIVW:   begin is_w = 1'b1; is_div_op = 1'b1; a_sgn_op = 1'b1; b_sgn_op = 1'b1; end
            OP_DIVUW:  begin is_w = 1'b1; is_div_op = 1'b1; end
            OP_REMW:   begin is_w = 1'b1; is_div_op = 1'b1; is_rem_op = 1'b1; a_sgn_op = 1'b1; b_sgn_op = 1'b1; end
            OP_REMUW:  begin is_w = 1'b1; is_div_op = 1'b1; is_rem_op = 1'b1; end
            default:   ;
        endcase
    end

    // ---------------------------------------------------------------
    // Operand preparation (IDLE sampling cycle)
    // ---------------------------------------------------------------
    logic [63:0] a_ext, b_ext, a_mag, b_mag, min_val, special_res;
    logic        a_neg, b_neg, div_zero, div_ovf;

    always_comb begin
        if (is_w) begin
            a_ext = a_sgn_op ? {{32{rs1data[31]}}, rs1data[31:0]} : {32'b0, rs1data[31:0]};
            b_ext = b_sgn_op ? {{32{rs2data[31]}}, rs2data[31:0]} : {32'b0, rs2data[31:0]};
        end else begin
            a_ext = rs1data;
            b_ext = rs2data;
        end
        a_neg   = a_sgn_op & a_ext[63];
        b_neg   = b_sgn_op & b_ext[63];
        // Magnitude of MIN is 2^63, which is still correct read as unsigned
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        min_val = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = (b_ext == 64'd0);
        // a_sgn_op is only set on signed div among the div ops
        div_ovf  = a_sgn_op & (a_ext == min_val) & (b_ext == {64{1'b1}});
        if (div_zero)
            special_res = is_rem_op ? a_ext : {64{1'b1}};
        else
            special_res = is_rem_op ? 64'd0 : min_val;
    end

    // ---------------------------------------------------------------
    // Multiply step and final selection
    // ---------------------------------------------------------------
    logic [127:0] mul_acc_nxt, mul_prod;
    logic [63:0]  mul_res;

    always_comb begin
        mul_acc_nxt = mplier[0] ? acc + mcand : acc;
        mul_prod    = neg_q ? -mul_acc_nxt : mul_acc_nxt;
        mul_res     = 64'd0;
        case (op_q)
            OP_MUL:                       mul_res = mul_prod[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mul_res = mul_prod[127:64];
            OP_MULW:                      mul_res = wfix(1'b1, mul_prod[63:0]);
            default:                      mul_res = 64'd0;
        endcase
    end

    // ---------------------------------------------------------------
    // Restoring divide step and final selection
    // ---------------------------------------------------------------
    // The shifted partial remainder can reach 65 bits for DIVU with a
    // divisor near 2^64, so the trial subtract carries an extra borrow bit.
    logic [64:0] div_sh;
    logic [65:0] div_diff;
    logic        div_ge;
    logic [63:0] rem_nxt, quo_nxt, div_q, div_r, div_res;

    always_comb begin
        div_sh   = {rem, quo[63]};
        div_diff = {1'b0, div_sh} - {2'b00, divisor};
        div_ge   = ~div_diff[65];
        rem_nxt  = div_ge ? div_diff[63:0] : div_sh[63:0];
        quo_nxt  = {quo[62:0], div_ge};
        div_q    = neg_q ? -quo_nxt : quo_nxt;
        div_r    = neg_r ? -rem_nxt : rem_nxt;
        div_res  = wfix(w_q, rem_q ? div_r : div_q);
    end

    assign stallreq = ((state == ST_IDLE) & start & ~flush) |
                      (state == ST_MUL) | (state == ST_DIV);

    // ---------------------------------------------------------------
    // FSM and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            result  <= 64'd0;
            done    <= 1'b0;
            cnt     <= 7'd0;
            op_q    <= 4'd0;
            w_q     <= 1'b0;
            rem_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= 128'd0;
            mcand   <= 128'd0;
            mplier  <= 64'd0;
            rem     <= 64'd0;
            quo     <= 64'd0;
            divisor <= 64'd0;
        end else if (flush) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        w_q     <= is_w;
                        rem_q   <= is_rem_op;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        cnt     <= is_w ? 7'd32 : 7'd64;
                        acc     <= 128'd0;
                        mcand   <= {64'd0, a_mag};
                        mplier  <= b_mag;
                        rem     <= 64'd0;
                        // W dividends are pre-aligned so the MSB-first
                        // shift starts at bit 31 of the word
                        quo     <= is_w ? {a_mag[31:0], 32'd0} : a_mag;
                        divisor <= b_mag;
                        if (is_div_op) begin
                            if (div_zero || div_ovf) begin
                                result <= wfix(is_w, special_res);
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                state <= ST_DIV;
                            end
                        end else begin
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        result <= mul_res;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        result <= div_res;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is ignored here so a held instruction does not re-trigger
                    if (!stall_in) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboard bench for exu_muldiv: stimulus pushes expected result and
// completion cycle; a negedge monitor pops on every rising edge of done.
module tb_exu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, flush, stall_in, start;
    logic [3:0]  op;
    logic [63:0] rs1data, rs2data, result;
    logic        done, stallreq;

    exu_muldiv #(.XLEN(64), .OP_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .stall_in (stall_in),
        .start    (start),
        .op       (op),
        .rs1data  (rs1data),
        .rs2data  (rs2data),
        .result   (result),
        .done     (done),
        .stallreq (stallreq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   done_q = 1'b0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: compare on each rising edge of done
    always @(negedge clk) begin
        if (done === 1'b1 && done_q == 1'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h want no completion", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_res"}, result, e.res);
                check({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
        done_q = (done === 1'b1);
    end

    // Drive one instruction for a single cycle; returns one cycle later
    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] r, input int lat, input string name, input bit push);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1data = a; rs2data = b;
        if (push) sb.push_back('{r, cyc + lat, name});
        #1 check({name, "_stallreq_start"}, {63'd0, stallreq}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        @(negedge clk);
        n = 1;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, max);
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] r, input int lat, input string name);
        issue(o, a, b, r, lat, name, 1'b1);
        wait_done(name, lat + 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; stall_in = 1'b0; start = 1'b0;
        op = 4'd0; rs1data = 64'd0; rs2data = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_stallreq", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MUL 7 * -3 with stallreq window check
        issue(4'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul", 1'b1);
        repeat (64) @(negedge clk);
        check("mul_stallreq_t64", {63'd0, stallreq}, 64'd1);
        @(negedge clk);
        check("mul_stallreq_t65", {63'd0, stallreq}, 64'd0);
        check("mul_done_t65", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        repeat (3) @(negedge clk);
        check("mul_result_hold", result, 64'hFFFF_FFFF_FFFF_FFEB);

        run(4'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu");
        run(4'd1, ONES, ONES, 64'd0, 65, "mulh");
        run(4'd2, ONES, 64'd2, ONES, 65, "mulhsu");
        run(4'd4, 64'd100, 64'd0, ONES, 1, "div_by0");
        run(4'd6, 64'd100, 64'd0, 64'd100, 1, "rem_by0");
        run(4'd4, MIN, ONES, MIN, 1, "div_ovf");
        run(4'd6, MIN, ONES, 64'd0, 1, "rem_ovf");
        run(4'd9, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw");
        run(4'd11, 64'h1_FFFF_FFF9, 64'd2, ONES, 33, "remw");
        run(4'd4, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_neg");
        run(4'd6, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_neg");
        run(4'd5, ONES, 64'd3, 64'h5555_5555_5555_5555, 65, "divu");
        run(4'd7, 64'd100, 64'd7, 64'd2, 65, "remu");
        run(4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw");
        run(4'd10, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, "divuw");
        run(4'd12, 64'd10, 64'd0, 64'd10, 1, "remuw_by0");
        run(4'd9, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");

        // stall_in held for 3 DONE cycles with start kept high
        @(posedge clk); #1;
        stall_in = 1'b1; start = 1'b1; op = 4'd8; rs1data = 64'd6; rs2data = 64'd7;
        sb.push_back('{64'd42, cyc + 33, "mulw_stall"});
        wait_done("mulw_stall", 40);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_done_%0d", i), {63'd0, done}, 64'd1);
            check($sformatf("stall_result_%0d", i), result, 64'd42);
            check($sformatf("stall_stallreq_%0d", i), {63'd0, stallreq}, 64'd0);
            @(posedge clk); #1;
            if (i == 2) stall_in = 1'b0;
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        check("stall_done_released", {63'd0, done}, 64'd0);
        repeat (5) @(negedge clk);

        // flush at T+10 of a DIVU
        issue(4'd5, 64'd1000, 64'd7, 64'd0, 0, "divu_flush", 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1 check("flush_stallreq", {63'd0, stallreq}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_result_kept", result, 64'd42);

        // synchronous reset in the middle of a MUL
        issue(4'd0, 64'd5, 64'd5, 64'd0, 0, "mul_rst", 1'b0);
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_stallreq", {63'd0, stallreq}, 64'd0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);

        // normal operation after the mid-op reset
        run(4'd0, 64'd5, 64'd5, 64'd25, 65, "mul_after_rst");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
